// File: rtl/fetch_stage.sv
// Sequential-prediction instruction fetch stage: one aligned block request in flight at a time,
// response unpacked into per-lane fetch packets for the instruction buffer.
module fetch_stage #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned IB_IDX_BITS = 3,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [IB_IDX_BITS:0]          available_slots,
  output logic [FETCH_WIDTH*97-1:0]     new_ib_entries,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          icache_req_valid,
  output logic [31:0]                   icache_req_addr,
  input  logic                          icache_req_ready,
  input  logic                          icache_rsp_valid,
  input  logic [FETCH_WIDTH*32-1:0]     icache_rsp_data,
  output logic [31:0]                   fetch_pc
);

  // Packet layout per lane: {valid, pc[31:0], npc[31:0], inst[31:0]}
  localparam int unsigned PKT_W      = 97;
  localparam int unsigned SLOT_W     = IB_IDX_BITS + 1;
  localparam int unsigned BLOCK_B    = FETCH_WIDTH * 4;
  localparam logic [31:0] BLOCK_MASK = ~(32'(BLOCK_B) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_pc, req_pc_next;
  logic [31:0] block_addr;
  logic [31:0] lane_pc;

  assign block_addr      = req_pc & BLOCK_MASK;
  assign icache_req_addr = pc & BLOCK_MASK;
  assign fetch_pc        = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      req_pc <= req_pc_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    req_pc_next      = req_pc;
    icache_req_valid = 1'b0;
    new_ib_entries   = '0;
    lane_pc          = '0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          // Late responses in IDLE (e.g. after reset) are ignored.
          if (redirect_valid) begin
            pc_next = redirect_pc;
          end else begin
            icache_req_valid = available_slots >= SLOT_W'(FETCH_WIDTH);
            if (icache_req_valid && icache_req_ready) begin
              state_next  = WAIT;
              req_pc_next = pc;
            end
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_next    = redirect_pc;
            state_next = icache_rsp_valid ? IDLE : DROP;
          end else if (icache_rsp_valid) begin
            // Lanes before the requested PC within the block are left invalid.
            for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
              lane_pc = block_addr + 32'(i * 4);
              if (lane_pc >= req_pc) begin
                new_ib_entries[i*PKT_W +: PKT_W] =
                  {1'b1, lane_pc, lane_pc + 32'd4, icache_rsp_data[i*32 +: 32]};
              end
            end
            pc_next    = block_addr + 32'(BLOCK_B);
            state_next = IDLE;
          end
        end
        DROP: begin
          if (redirect_valid) begin
            pc_next = redirect_pc;
          end
          if (icache_rsp_valid) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch PC and outstanding request.
module tb_fetch_stage;

  localparam int unsigned FW  = 4;
  localparam int unsigned EW  = FW * 97;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    available_slots;
  logic [EW-1:0] new_ib_entries;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          icache_req_valid;
  logic [31:0]   icache_req_addr;
  logic          icache_req_ready;
  logic          icache_rsp_valid;
  logic [127:0]  icache_rsp_data;
  logic [31:0]   fetch_pc;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.FETCH_WIDTH(FW), .IB_IDX_BITS(3), .RESET_PC(32'h0)) dut (
    .clock           (clk),
    .reset           (reset),
    .available_slots (available_slots),
    .new_ib_entries  (new_ib_entries),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .icache_req_valid(icache_req_valid),
    .icache_req_addr (icache_req_addr),
    .icache_req_ready(icache_req_ready),
    .icache_rsp_valid(icache_rsp_valid),
    .icache_rsp_data (icache_rsp_data),
    .fetch_pc        (fetch_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [96:0] lane(input logic [EW-1:0] v, input int i);
    return v[i*97 +: 97];
  endfunction

  // Expected packets from the requested PC: lanes from its word offset onward are live.
  function automatic logic [EW-1:0] model_block(input logic [31:0] rpc, input logic [127:0] data);
    logic [EW-1:0] r;
    logic [31:0]   base;
    int unsigned   first;
    r     = '0;
    first = (rpc % 16) / 4;
    base  = rpc - (rpc % 16);
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(first))
        r[i*97 +: 97] = {1'b1, base + 32'(4*i), base + 32'(4*i + 4), data[i*32 +: 32]};
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; available_slots = 4'd8;
    icache_req_ready = 1'b1; icache_rsp_valid = 1'b0; icache_rsp_data = '0;
    tick(); tick();
    total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", icache_req_valid); end
    total++; if (new_ib_entries !== '0) begin bad++; $display("FAIL reset_entries got=%h exp=0", new_ib_entries); end
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL reset_fetch_pc got=%h exp=0", fetch_pc); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [127:0] d;
    logic [96:0]  l;
    for (int b = 0; b < 3; b++) begin
      #1;
      total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'(b*16)) begin
        bad++; $display("FAIL seq_req b=%0d got=%b/%h exp=1/%h", b, icache_req_valid, icache_req_addr, 32'(b*16)); end
      total++; if (fetch_pc !== 32'(b*16)) begin bad++; $display("FAIL seq_pc got=%h exp=%h", fetch_pc, 32'(b*16)); end
      tick();
      d = {$urandom, $urandom, $urandom, $urandom};
      icache_rsp_valid = 1'b1; icache_rsp_data = d; #1;
      total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL seq_no_req_in_wait got=%b exp=0", icache_req_valid); end
      for (int i = 0; i < 4; i++) begin
        l = lane(new_ib_entries, i);
        total++; if (l !== {1'b1, 32'(b*16 + 4*i), 32'(b*16 + 4*i + 4), d[i*32 +: 32]}) begin
          bad++; $display("FAIL seq_lane b=%0d i=%0d got=%h", b, i, l); end
      end
      tick();
      icache_rsp_valid = 1'b0;
    end
  endtask

  task automatic test_redirect_idle();
    logic [127:0] d;
    logic [96:0]  l;
    redirect_valid = 1'b1; redirect_pc = 32'h14; #1;
    total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL redir_idle_req got=%b exp=0", icache_req_valid); end
    tick();
    redirect_valid = 1'b0; #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h10) begin
      bad++; $display("FAIL redir_idle_addr got=%b/%h exp=1/10", icache_req_valid, icache_req_addr); end
    total++; if (fetch_pc !== 32'h14) begin bad++; $display("FAIL redir_idle_pc got=%h exp=14", fetch_pc); end
    tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    icache_rsp_valid = 1'b1; icache_rsp_data = d; #1;
    total++; if (lane(new_ib_entries, 0) !== 97'h0) begin bad++; $display("FAIL redir_idle_lane0 got=%h exp=0", lane(new_ib_entries, 0)); end
    for (int i = 1; i < 4; i++) begin
      l = lane(new_ib_entries, i);
      total++; if (l !== {1'b1, 32'(16 + 4*i), 32'(20 + 4*i), d[i*32 +: 32]}) begin
        bad++; $display("FAIL redir_idle_lane i=%0d got=%h", i, l); end
    end
    tick();
    icache_rsp_valid = 1'b0; #1;
    total++; if (fetch_pc !== 32'h20) begin bad++; $display("FAIL redir_idle_next_pc got=%h exp=20", fetch_pc); end
  endtask

  task automatic test_redirect_wait();
    #1;
    total++; if (icache_req_addr !== 32'h20) begin bad++; $display("FAIL redir_wait_req got=%h exp=20", icache_req_addr); end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    total++; if (new_ib_entries !== '0) begin bad++; $display("FAIL redir_wait_push got=%h exp=0", new_ib_entries); end
    tick();
    redirect_valid = 1'b0; #1;
    total++; if (icache_req_valid !== 1'b0 || fetch_pc !== 32'h40) begin
      bad++; $display("FAIL drop_state got=%b/%h exp=0/40", icache_req_valid, fetch_pc); end
    tick();
    icache_rsp_valid = 1'b1; icache_rsp_data = {4{32'hDEADBEEF}}; #1;
    total++; if (new_ib_entries !== '0 || icache_req_valid !== 1'b0) begin
      bad++; $display("FAIL drop_discard got=%h/%b exp=0/0", new_ib_entries, icache_req_valid); end
    tick();
    icache_rsp_valid = 1'b0; #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h40) begin
      bad++; $display("FAIL drop_next_req got=%b/%h exp=1/40", icache_req_valid, icache_req_addr); end
  endtask

  task automatic test_redirect_with_rsp();
    logic [127:0] d;
    logic [96:0]  l;
    tick();
    icache_rsp_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h84; #1;
    total++; if (new_ib_entries !== '0) begin bad++; $display("FAIL redir_rsp_push got=%h exp=0", new_ib_entries); end
    tick();
    icache_rsp_valid = 1'b0; redirect_valid = 1'b0; #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h80 || fetch_pc !== 32'h84) begin
      bad++; $display("FAIL redir_rsp_next got=%b/%h/%h exp=1/80/84", icache_req_valid, icache_req_addr, fetch_pc); end
    tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    icache_rsp_valid = 1'b1; icache_rsp_data = d; #1;
    l = lane(new_ib_entries, 1);
    total++; if (lane(new_ib_entries, 0) !== 97'h0 || l !== {1'b1, 32'h84, 32'h88, d[63:32]}) begin
      bad++; $display("FAIL redir_rsp_lanes got=%h", new_ib_entries); end
    tick();
    icache_rsp_valid = 1'b0;
  endtask

  task automatic test_throttle();
    available_slots = 4'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (icache_req_valid !== 1'b0) begin bad++; $display("FAIL throttle_hold c=%0d got=%b exp=0", c, icache_req_valid); end
      tick();
    end
    available_slots = 4'd4; icache_req_ready = 1'b0; #1;
    total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h90) begin
      bad++; $display("FAIL throttle_release got=%b/%h exp=1/90", icache_req_valid, icache_req_addr); end
    tick();
    available_slots = 4'd8;
  endtask

  task automatic test_stall_wrap();
    logic [127:0] d;
    logic [96:0]  l;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
    tick();
    redirect_valid = 1'b0; icache_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'hFFFF_FFF0) begin
        bad++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/fffffff0", c, icache_req_valid, icache_req_addr); end
      tick();
    end
    icache_req_ready = 1'b1;
    tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    icache_rsp_valid = 1'b1; icache_rsp_data = d; #1;
    for (int i = 0; i < 4; i++) begin
      l = lane(new_ib_entries, i);
      total++; if (l !== {1'b1, 32'hFFFF_FFF0 + 32'(4*i), 32'hFFFF_FFF4 + 32'(4*i), d[i*32 +: 32]}) begin
        bad++; $display("FAIL wrap_lane i=%0d got=%h", i, l); end
    end
    tick();
    icache_rsp_valid = 1'b0; #1;
    total++; if (icache_req_addr !== 32'h0 || fetch_pc !== 32'h0) begin
      bad++; $display("FAIL wrap_next got=%h/%h exp=0/0", icache_req_addr, fetch_pc); end
  endtask

  task automatic test_reset_mid_request();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; icache_req_ready = 1'b0;
    icache_rsp_valid = 1'b1; icache_rsp_data = {4{32'h12345678}}; #1;
    total++; if (new_ib_entries !== '0 || fetch_pc !== 32'h0 || icache_req_valid !== 1'b1) begin
      bad++; $display("FAIL late_rsp got=%h/%h/%b exp=0/0/1", new_ib_entries, fetch_pc, icache_req_valid); end
    tick();
    icache_rsp_valid = 1'b0; icache_req_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0]  m_pc, m_req, rpc, exp_addr;
    logic         m_out, m_sq, cache_pend, redir, rsp, exp_valid, accept;
    int           cache_wait;
    logic [127:0] d;
    logic [EW-1:0] exp_e;
    reset = 1'b1; tick(); reset = 1'b0;
    m_pc = 32'h0; m_req = 32'h0; m_out = 1'b0; m_sq = 1'b0; cache_pend = 1'b0; cache_wait = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      redir = ($urandom_range(0, 9) == 0);
      rpc   = ($urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(0, 255))) & ~32'd3;
      rsp   = cache_pend && (cache_wait == 0);
      d     = {$urandom, $urandom, $urandom, $urandom};
      redirect_valid = redir; redirect_pc = rpc;
      available_slots = 4'($urandom_range(0, 8));
      icache_req_ready = ($urandom_range(0, 3) != 0);
      icache_rsp_valid = rsp; icache_rsp_data = d;
      #1;
      exp_valid = !m_out && !redir && (available_slots >= 4'd4);
      exp_addr  = m_pc - (m_pc % 16);
      exp_e     = (m_out && !m_sq && rsp && !redir) ? model_block(m_req, d) : '0;
      total++; if (icache_req_valid !== exp_valid) begin
        bad++; $display("FAIL rand_req_valid cyc=%0d got=%b exp=%b", cyc, icache_req_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (icache_req_addr !== exp_addr) begin
          bad++; $display("FAIL rand_req_addr cyc=%0d got=%h exp=%h", cyc, icache_req_addr, exp_addr); end
      end
      total++; if (new_ib_entries !== exp_e) begin
        bad++; $display("FAIL rand_entries cyc=%0d got=%h exp=%h", cyc, new_ib_entries, exp_e); end
      total++; if (fetch_pc !== m_pc) begin
        bad++; $display("FAIL rand_fetch_pc cyc=%0d got=%h exp=%h", cyc, fetch_pc, m_pc); end
      accept = exp_valid && icache_req_ready;
      if (redir) begin
        m_pc = rpc;
        if (m_out) begin
          if (rsp) begin m_out = 1'b0; m_sq = 1'b0; end
          else m_sq = 1'b1;
        end
      end else if (!m_out) begin
        if (accept) begin m_out = 1'b1; m_req = m_pc; end
      end else if (rsp) begin
        if (!m_sq) m_pc = m_req - (m_req % 16) + 32'd16;
        m_out = 1'b0; m_sq = 1'b0;
      end
      if (rsp) cache_pend = 1'b0;
      else if (cache_pend) cache_wait--;
      if (accept) begin cache_pend = 1'b1; cache_wait = $urandom_range(0, 2); end
      tick();
    end
    redirect_valid = 1'b0; icache_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_with_rsp();
    test_throttle();
    test_stall_wrap();
    test_reset_mid_request();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
